pln_skid_stage: RTL and testbench
=================================

# pln_skid_stage

Parametrised, handshaked pipeline-stage register for the multicycle/pipelined MIPS datapath: a generalisation of the fixed per-stage D/E/M/W registers. It carries an arbitrary-width stage bundle (instr, PC, operands, ...) with valid/ready flow control and a two-entry skid buffer, so stalls propagate without a combinational ready path. It also provides synchronous flush-to-bubble. Instantiated once per stage boundary between the hazard unit and the next stage.

## Interface
- DATA_W, 64: width of the stage bundle (e.g. {instr, PC4}).
- BUBBLE_VAL, {DATA_W{1'b0}}: value presented when empty or flushed (all-zero instr = MIPS nop).
- CNT_W, 32: width of each performance counter (only with PLN_PERF_CNT_EN).
- PLN_clk  in  1  stage clock; all state updates on its rising edge.
- PLN_reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid bundle.
- in_ready  out  1  stage can accept; depends on registered state only.
- in_data  in  DATA_W  upstream bundle.
- out_valid  out  1  out_data is a valid bundle.
- out_ready  in  1  downstream consumes (low = stall from hazard unit).
- out_data  out  DATA_W  bundle to next stage; BUBBLE_VAL when out_valid=0.
- flush  in  1  synchronous kill of all held entries.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  present only with PLN_PERF_CNT_EN.

## Operation
- Storage: main register (drives out_data) and skid register. State EMPTY/ONE/FULL (occupancy 0/1/2).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != FULL); out_valid = (state != EMPTY).
- EMPTY: in_fire -> ONE, main <= in_data.
- ONE: in_fire & out_fire -> ONE, main <= in_data.
- ONE: in_fire & !out_fire -> FULL, skid <= in_data.
- ONE: !in_fire & out_fire -> EMPTY, main <= BUBBLE_VAL.
- ONE: neither -> hold.
- FULL: out_fire -> ONE, main <= skid, skid <= BUBBLE_VAL.
- FULL: otherwise hold. in_ready=0, so in_valid is ignored.
- Flush has highest priority:
  - Next state EMPTY; main and skid <= BUBBLE_VAL.
  - A simultaneous in_fire is discarded.
  - A simultaneous out_fire counts as consumed downstream.
- Ordering: strict FIFO. No bundle is duplicated or dropped, except by flush or reset.
- Reset asserted at any time, including mid-transfer:
  - Immediately: state EMPTY, main/skid = BUBBLE_VAL, counters 0.
  - Outputs: out_valid=0, in_ready=1, occupancy=0.

## Timing
- Latency: bundle accepted at edge k is on out_data after edge k (1 cycle), if it is at the head.
- Throughput: 1 bundle/cycle sustained while out_ready=1.
- No combinational path from out_ready or in_valid to in_ready. in_ready and out_valid come from state flops only.
- out_ready dropping to 0 while in_valid=1: the stage absorbs one more bundle (FULL), then in_ready=0 from the next cycle.
- Flush effect visible after the flush edge: out_valid=0, out_data=BUBBLE_VAL.

## Configuration
- PLN_PERF_CNT_EN defined:
  - stall_cnt: +1 per cycle with out_valid & !out_ready.
  - bubble_cnt: +1 per cycle with !out_valid (not counted while in reset).
  - flush_cnt: +1 per cycle flush=1.
  - All counters saturate at all-ones and clear only on reset.
- Undefined: counter ports and logic absent. Datapath behaviour is identical.

## Structure
- Shared package pln_pkg:
  - State encoding PLN_EMPTY=2'd0, PLN_ONE=2'd1, PLN_FULL=2'd2.
  - Default bubble constant.
- Sub-module pln_sat_cnt: parameter CNT_W; ports clk, async active-low reset, inc, count. Saturating. Instantiated three times under PLN_PERF_CNT_EN.

## Test plan
- Streaming: out_ready=1; in_data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later, back-to-back; occupancy stays 1; in_ready=1 throughout.
- Stall fill: out_ready=0 from cycle 3 with continuous input:
  - FULL with 0x3 in main, 0x4 in skid; in_ready=0 after that edge.
  - out_ready=1 -> 0x3, 0x4, 0x5... with no loss or duplication.
- Flush in FULL with in_valid=1 (data 0xAA):
  - Next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0.
  - 0xAA is never emitted.
- Reset mid-stream: drop PLN_reset_n between edges while FULL -> outputs clear immediately without a clock edge; after release, first input 0x55 emerges one cycle later.
- Alternating out_ready 1/0 with random in_valid (10k cycles):
  - Scoreboard: output sequence equals accepted input sequence.
  - in_ready never depends combinationally on out_ready.
- PLN_PERF_CNT_EN, CNT_W=4: hold a stall for 20 cycles -> stall_cnt saturates at 15; 3 flush pulses -> flush_cnt=3.

Source files
------------

// File: rtl/pln_pkg.sv
// ============================================================================
//  Module      : pln_pkg
//  Description : Shared definitions for the pipeline skid stage: occupancy
//                state encoding and the default bubble fill value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pln_pkg;

    // Occupancy state encoding; the value doubles as the entry count.
    localparam logic [1:0] PLN_EMPTY = 2'd0;
    localparam logic [1:0] PLN_ONE   = 2'd1;
    localparam logic [1:0] PLN_FULL  = 2'd2;

    // Fill bit for the default bubble: all-zero instr word is a MIPS nop.
    localparam logic PLN_BUBBLE_BIT = 1'b0;

endpackage : pln_pkg

`default_nettype wire

// File: rtl/pln_sat_cnt.sv
// ============================================================================
//  Module      : pln_sat_cnt
//  Description : Saturating up-counter with asynchronous active-low reset.
//                Sticks at all-ones; only reset clears it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pln_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // Count up on inc, stopping at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : pln_sat_cnt

`default_nettype wire

// File: rtl/pln_skid_stage.sv
// ============================================================================
//  Module      : pln_skid_stage
//  Description : Handshaked pipeline-stage register with a two-entry skid
//                buffer and synchronous flush-to-bubble. in_ready/out_valid
//                are decoded from state flops only, so stalls never form a
//                combinational ready chain across stages.
//                Optional macro PLN_PERF_CNT_EN adds saturating stall,
//                bubble and flush performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pln_skid_stage
    import pln_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{PLN_BUBBLE_BIT}}
`ifdef PLN_PERF_CNT_EN
    ,
    parameter int                CNT_W      = 32
`endif
) (
    input  logic              PLN_clk,
    input  logic              PLN_reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy
`ifdef PLN_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_in_fire;
    logic              w_out_fire;

    assign in_ready   = (r_state != PLN_FULL);
    assign out_valid  = (r_state != PLN_EMPTY);
    assign out_data   = r_main;
    assign occupancy  = r_state;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Occupancy FSM with main/skid storage; flush overrides every transition.
    always_ff @(posedge PLN_clk or negedge PLN_reset_n) begin
        if (!PLN_reset_n) begin
            r_state <= PLN_EMPTY;
            r_main  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
        end else if (flush) begin
            r_state <= PLN_EMPTY;
            r_main  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
        end else begin
            case (r_state)
                PLN_EMPTY: begin
                    if (w_in_fire) begin
                        r_state <= PLN_ONE;
                        r_main  <= in_data;
                    end
                end
                PLN_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main  <= in_data;
                    end else if (w_in_fire) begin
                        r_state <= PLN_FULL;
                        r_skid  <= in_data;
                    end else if (w_out_fire) begin
                        r_state <= PLN_EMPTY;
                        r_main  <= BUBBLE_VAL;
                    end
                end
                PLN_FULL: begin
                    // in_ready is low here, so only the drain path matters.
                    if (w_out_fire) begin
                        r_state <= PLN_ONE;
                        r_main  <= r_skid;
                        r_skid  <= BUBBLE_VAL;
                    end
                end
                default: begin
                    r_state <= PLN_EMPTY;
                    r_main  <= BUBBLE_VAL;
                    r_skid  <= BUBBLE_VAL;
                end
            endcase
        end
    end

`ifdef PLN_PERF_CNT_EN
    pln_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (PLN_clk),
        .rst_n (PLN_reset_n),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    pln_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (PLN_clk),
        .rst_n (PLN_reset_n),
        .inc   (~out_valid),
        .count (bubble_cnt)
    );

    pln_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (PLN_clk),
        .rst_n (PLN_reset_n),
        .inc   (flush),
        .count (flush_cnt)
    );
`endif

endmodule : pln_skid_stage

`default_nettype wire

// File: tb/tb_pln_skid_stage.sv
// ============================================================================
//  Module      : tb_pln_skid_stage
//  Description : Directed and scoreboarded bench for pln_skid_stage
//                (DATA_W=8, zero bubble). Counter checks need PLN_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pln_skid_stage;

    localparam int c_DW = 8;

    logic            PLN_clk;
    logic            PLN_reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [c_DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [c_DW-1:0] out_data;
    logic            flush;
    logic [1:0]      occupancy;
`ifdef PLN_PERF_CNT_EN
    logic [3:0]      stall_cnt;
    logic [3:0]      bubble_cnt;
    logic [3:0]      flush_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    pln_skid_stage #(
        .DATA_W (c_DW)
`ifdef PLN_PERF_CNT_EN
        ,
        .CNT_W  (4)
`endif
    ) u_dut (
        .PLN_clk     (PLN_clk),
        .PLN_reset_n (PLN_reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .occupancy   (occupancy)
`ifdef PLN_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    initial PLN_clk = 1'b0;
    always #5 PLN_clk = ~PLN_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge PLN_clk);
        #1;
    endtask

    task automatic do_reset();
        PLN_reset_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) tick();
        @(negedge PLN_clk);
        PLN_reset_n = 1'b1;
        tick();
    endtask

    logic [c_DW-1:0] q[$];
    logic [c_DW-1:0] exp_d;
    logic            ir_a;
    logic            pre_in_fire;
    logic            pre_out_fire;

    initial begin
        // ---------------- reset state ----------------
        PLN_reset_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_occ",       occupancy, 0);
        chk("rst_out_data",  out_data,  0);
        do_reset();

        // ---------------- streaming ----------------
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = c_DW'(i);
            tick();
            chk("stream_data",  out_data,  i);
            chk("stream_valid", out_valid, 1);
            chk("stream_occ",   occupancy, 1);
            chk("stream_ready", in_ready,  1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", out_valid, 0);
        chk("stream_drain_data",  out_data,  0);

        // ---------------- stall fill ----------------
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = c_DW'(i);
            tick();
        end
        chk("fill_pre_data", out_data, 3);
        out_ready = 1'b0; in_data = 8'h04;
        tick();
        chk("fill_occ",   occupancy, 2);
        chk("fill_main",  out_data,  8'h03);
        chk("fill_ready", in_ready,  0);
        in_data = 8'h05;
        tick();
        chk("fill_hold_occ",  occupancy, 2);
        chk("fill_hold_data", out_data,  8'h03);
        out_ready = 1'b1;
        tick();
        chk("drain_4",     out_data,  8'h04);
        chk("drain_4_occ", occupancy, 1);
        chk("drain_4_rdy", in_ready,  1);
        tick();
        chk("drain_5", out_data, 8'h05);
        in_data = 8'h06;
        tick();
        chk("drain_6", out_data, 8'h06);
        in_valid = 1'b0;
        tick();
        chk("drain_empty", out_valid, 0);

        // ---------------- flush in FULL ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        chk("fl_full_occ", occupancy, 2);
        in_data = 8'hAA; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_data",  out_data,  0);
        chk("fl_occ",   occupancy, 0);
        chk("fl_ready", in_ready,  1);
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("fl_no_aa", out_valid, 0);
        end

        // ---------------- flush in ONE discards simultaneous input ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h33; tick();
        in_data = 8'hBB; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl1_occ", occupancy, 0);
        tick();
        chk("fl1_no_bb", out_valid, 0);

        // ---------------- asynchronous reset while FULL ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h44; tick();
        in_data = 8'h45; tick();
        chk("ar_full", occupancy, 2);
        #2 PLN_reset_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready,  1);
        chk("ar_occ",   occupancy, 0);
        chk("ar_data",  out_data,  0);
        #2 PLN_reset_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        tick();
        chk("ar_first_data",  out_data,  8'h55);
        chk("ar_first_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();

        // ---------------- alternating out_ready, random in_valid ----------------
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            out_ready = c[0] ? 1'b0 : 1'b1;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = c_DW'($urandom);
            ir_a = in_ready;
            out_ready = ~out_ready;
            #1;
            chk("rnd_ready_indep", in_ready, ir_a);
            out_ready = ~out_ready;
            #1;
            pre_in_fire  = in_valid & in_ready;
            pre_out_fire = out_valid & out_ready;
            if (pre_out_fire) begin
                exp_d = q.pop_front();
                chk("rnd_data", out_data, exp_d);
            end
            if (pre_in_fire) q.push_back(in_data);
            tick();
            chk("rnd_occ",   occupancy, q.size());
            chk("rnd_ready", in_ready,  (q.size() < 2) ? 1 : 0);
        end
        in_valid = 1'b0;

`ifdef PLN_PERF_CNT_EN
        // ---------------- performance counters ----------------
        do_reset();
        chk("pc_rst_stall", stall_cnt, 0);
        in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("pc_stall_sat", stall_cnt, 15);
        repeat (3) begin
            flush = 1'b1; tick();
            flush = 1'b0; tick();
        end
        chk("pc_flush", flush_cnt, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pln_skid_stage

`default_nettype wire
